// File: rtl/dcache_wb_dm_pkg.sv
// Shared constants and types for the direct-mapped write-back data cache.
package dcache_wb_dm_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int OFF_W   = 2;
    localparam int ADDR_W  = 30;
    localparam int BADDR_W = ADDR_W - OFF_W;

    localparam logic [1:0] ST_COMPARE   = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    function automatic int index_w(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int tag_w(input int num_blocks);
        return BADDR_W - $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/dcache_wb_dm_if.sv
// Core-side and memory-side buses of the data cache, seen from the cache (slave) or its environment (master).
interface dcache_wb_dm_if;
    import dcache_wb_dm_pkg::*;

    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    word_t               proc_wdata;
    logic                proc_stall;
    word_t               proc_rdata;

    logic                mem_read;
    logic                mem_write;
    logic [BADDR_W-1:0]  mem_addr;
    block_t              mem_wdata;
    logic                mem_ready;
    block_t              mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data per line, with a word-store port, a block-fill port and a combinational line read.
module dcache_line_array
    import dcache_wb_dm_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    localparam int IW         = index_w(NUM_BLOCKS),
    localparam int TW         = tag_w(NUM_BLOCKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    i_index,
    input  logic             i_word_we,
    input  logic [OFF_W-1:0] i_word_off,
    input  word_t            i_word_data,
    input  logic             i_fill_we,
    input  logic [TW-1:0]    i_fill_tag,
    input  block_t           i_fill_data,
    output logic             o_valid,
    output logic             o_dirty,
    output logic [TW-1:0]    o_tag,
    output block_t           o_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TW-1:0]         r_tag  [NUM_BLOCKS];
    block_t                r_data [NUM_BLOCKS];

    // Status bits: the only storage reset has to clear; a fill always leaves the line clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tag and data payload: a whole block on refill, one word on a store hit.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_data;
        end else if (i_word_we) begin
            r_data[i_index][{i_word_off, 5'd0} +: WORD_W] <= i_word_data;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache: hit logic and the COMPARE/WRITEBACK/ALLOCATE miss FSM.
module dcache_wb_dm
    import dcache_wb_dm_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic          clk,
    input  logic          rst,
    dcache_wb_dm_if.slave bus
);

    localparam int IW = index_w(NUM_BLOCKS);
    localparam int TW = tag_w(NUM_BLOCKS);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [OFF_W-1:0] w_off;
    logic [IW-1:0]    w_index;
    logic [TW-1:0]    w_tag;
    logic             w_req;
    logic             w_hit;
    logic             w_line_valid;
    logic             w_line_dirty;
    logic [TW-1:0]    w_line_tag;
    block_t           w_line_data;
    logic             w_word_we;
    logic             w_fill_we;

    assign w_off   = bus.proc_addr[OFF_W-1:0];
    assign w_index = bus.proc_addr[OFF_W+IW-1:OFF_W];
    assign w_tag   = bus.proc_addr[ADDR_W-1:OFF_W+IW];
    assign w_req   = bus.proc_read | bus.proc_write;
    assign w_hit   = w_line_valid && (w_line_tag == w_tag);

    dcache_line_array #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_lines (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_word_we   (w_word_we),
        .i_word_off  (w_off),
        .i_word_data (bus.proc_wdata),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (bus.mem_rdata),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_tag       (w_line_tag),
        .o_data      (w_line_data)
    );

    // Next state and array write strobes; a read+write request is treated as a write.
    always_comb begin
        w_state_nxt = r_state;
        w_word_we   = 1'b0;
        w_fill_we   = 1'b0;
        case (r_state)
            ST_COMPARE: begin
                if (!w_req) begin
                    w_state_nxt = ST_COMPARE;
                end else if (w_hit) begin
                    w_word_we = bus.proc_write;
                end else if (w_line_valid && w_line_dirty) begin
                    w_state_nxt = ST_WRITEBACK;
                end else begin
                    w_state_nxt = ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_ALLOCATE;
                end else begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (bus.mem_ready) begin
                    w_fill_we   = 1'b1;
                    w_state_nxt = ST_COMPARE;
                end else begin
                    w_state_nxt = ST_ALLOCATE;
                end
            end
            default: begin
                w_state_nxt = ST_COMPARE;
            end
        endcase
    end

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COMPARE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory bus decode: write-back addresses the victim line, refill addresses the request.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = bus.proc_addr[ADDR_W-1:OFF_W];
        if (r_state == ST_WRITEBACK) begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = {w_line_tag, w_index};
        end else if (r_state == ST_ALLOCATE) begin
            bus.mem_read  = 1'b1;
        end else begin
            bus.mem_read  = 1'b0;
        end
    end

    assign bus.mem_wdata  = w_line_data;
    assign bus.proc_rdata = w_line_data[{w_off, 5'd0} +: WORD_W];
    assign bus.proc_stall = w_req && !((r_state == ST_COMPARE) && w_hit);

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed self-checking bench for dcache_wb_dm with a block memory model answering 3 cycles after a request rises.
module tb_dcache_wb_dm;

    localparam int MEM_WAIT = 3;

    localparam logic [31:0] WA = 32'h1111_0000;
    localparam logic [31:0] WB = 32'h2222_0001;
    localparam logic [31:0] WC = 32'h3333_0002;
    localparam logic [31:0] WD = 32'h4444_0003;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   mem_auto;
    bit   inject;

    logic [127:0] mem_model [logic [27:0]];
    bit           log_wr   [$];
    logic [27:0]  log_addr [$];
    logic [127:0] log_data [$];

    dcache_wb_dm_if bus ();

    dcache_wb_dm #(.NUM_BLOCKS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(bus.proc_read && bus.proc_write))
                else $error("illegal request: proc_read and proc_write both high");
        end
    end

    // Memory responder: pulses mem_ready on the 4th cycle a request is seen, or on demand (inject).
    initial begin : mem_responder
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 128'h0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (rst === 1'b0) begin
                n_cmp++;
                if ((bus.mem_read && bus.mem_write) !== 1'b0) begin
                    n_err++;
                    $display("FAIL mem_exclusive: mem_read=%b mem_write=%b required not both 1",
                             bus.mem_read, bus.mem_write);
                end
            end
            if (inject) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = {4{32'hBAD0_BAD0}};
                cnt = 0;
            end else if (rst !== 1'b0) begin
                cnt = 0;
            end else if (mem_auto && (bus.mem_read || bus.mem_write)) begin
                cnt++;
                if (cnt == MEM_WAIT + 1) begin
                    cnt = 0;
                    bus.mem_ready = 1'b1;
                    log_wr.push_back(bus.mem_write);
                    log_addr.push_back(bus.mem_addr);
                    if (bus.mem_write) begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                        log_data.push_back(bus.mem_wdata);
                    end else begin
                        bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 128'h0;
                        log_data.push_back(bus.mem_rdata);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rdata, output bit to);
        stalls = 0;
        rdata  = 32'h0;
        to     = 1'b0;
        @(posedge clk); #1;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        forever begin
            @(negedge clk);
            if (bus.proc_stall === 1'b0) begin
                rdata = bus.proc_rdata;
                break;
            end
            stalls++;
            if (stalls >= 200) begin
                to = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.proc_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.proc_stall); end
        n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read: got %b want 0", bus.mem_read); end
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
    endtask

    task automatic test_cold_read();
        int st; logic [31:0] rd; bit to; int n0;
        n0 = log_wr.size();
        issue(1'b1, 1'b0, 30'h10, 32'h0, st, rd, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL cold_timeout: request never completed"); end
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL cold_stall: got %0d cycles want 5", st); end
        n_cmp++; if (rd !== WA) begin n_err++; $display("FAIL cold_rdata: got %h want %h", rd, WA); end
        n_cmp++; if (log_wr.size() !== n0 + 1) begin n_err++; $display("FAIL cold_txn_count: got %0d want %0d", log_wr.size(), n0 + 1); end
        else begin
            n_cmp++; if ({log_wr[n0], log_addr[n0]} !== {1'b0, 28'h4}) begin n_err++; $display("FAIL cold_txn: got wr=%b addr=%h want read addr 4", log_wr[n0], log_addr[n0]); end
        end
        issue(1'b1, 1'b0, 30'h13, 32'h0, st, rd, to);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL hit13_stall: got %0d want 0", st); end
        n_cmp++; if (rd !== WD) begin n_err++; $display("FAIL hit13_rdata: got %h want %h", rd, WD); end
    endtask

    task automatic test_write_hit();
        int st; logic [31:0] rd; bit to; int n0;
        n0 = log_wr.size();
        issue(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, st, rd, to);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL whit_stall: got %0d want 0", st); end
        issue(1'b1, 1'b0, 30'h11, 32'h0, st, rd, to);
        n_cmp++; if ({st == 0, rd} !== {1'b1, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL whit_read11: got stall=%0d data=%h want 0/deadbeef", st, rd); end
        issue(1'b1, 1'b0, 30'h12, 32'h0, st, rd, to);
        n_cmp++; if ({st == 0, rd} !== {1'b1, WC}) begin n_err++; $display("FAIL whit_read12: got stall=%0d data=%h want 0/%h", st, rd, WC); end
        n_cmp++; if (log_wr.size() !== n0) begin n_err++; $display("FAIL whit_no_mem: got %0d txns want 0", log_wr.size() - n0); end
    endtask

    task automatic test_dirty_eviction();
        int st; logic [31:0] rd; bit to; int n0;
        n0 = log_wr.size();
        issue(1'b1, 1'b0, 30'h31, 32'h0, st, rd, to);
        n_cmp++; if (st !== 9) begin n_err++; $display("FAIL evict_stall: got %0d want 9", st); end
        n_cmp++; if (rd !== 32'h5555_0001) begin n_err++; $display("FAIL evict_rdata: got %h want 55550001", rd); end
        n_cmp++; if (log_wr.size() !== n0 + 2) begin n_err++; $display("FAIL evict_txn_count: got %0d want %0d", log_wr.size(), n0 + 2); end
        else begin
            n_cmp++; if ({log_wr[n0], log_addr[n0]} !== {1'b1, 28'h4}) begin n_err++; $display("FAIL evict_wb_addr: got wr=%b addr=%h want write addr 4", log_wr[n0], log_addr[n0]); end
            n_cmp++; if (log_data[n0] !== {WD, WC, 32'hDEAD_BEEF, WA}) begin n_err++; $display("FAIL evict_wb_data: got %h want %h", log_data[n0], {WD, WC, 32'hDEAD_BEEF, WA}); end
            n_cmp++; if ({log_wr[n0+1], log_addr[n0+1]} !== {1'b0, 28'hC}) begin n_err++; $display("FAIL evict_fill: got wr=%b addr=%h want read addr c", log_wr[n0+1], log_addr[n0+1]); end
        end
    endtask

    task automatic test_write_miss_allocate();
        int st; logic [31:0] rd; bit to; int n0;
        n0 = log_wr.size();
        issue(1'b0, 1'b1, 30'h55, 32'h1234_5678, st, rd, to);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL wmiss_stall: got %0d want 5", st); end
        n_cmp++; if (log_wr.size() !== n0 + 1) begin n_err++; $display("FAIL wmiss_txn_count: got %0d want %0d", log_wr.size(), n0 + 1); end
        else begin
            n_cmp++; if ({log_wr[n0], log_addr[n0]} !== {1'b0, 28'h15}) begin n_err++; $display("FAIL wmiss_fill: got wr=%b addr=%h want read addr 15", log_wr[n0], log_addr[n0]); end
        end
        issue(1'b1, 1'b0, 30'h55, 32'h0, st, rd, to);
        n_cmp++; if ({st == 0, rd} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL wmiss_merge: got stall=%0d data=%h want 0/12345678", st, rd); end
        n0 = log_wr.size();
        issue(1'b1, 1'b0, 30'h35, 32'h0, st, rd, to);
        n_cmp++; if ({st, rd} !== {32'd9, 32'h7777_0001}) begin n_err++; $display("FAIL wmiss_conflict: got stall=%0d data=%h want 9/77770001", st, rd); end
        n_cmp++; if (log_wr.size() !== n0 + 2) begin n_err++; $display("FAIL wmiss_wb_count: got %0d want %0d", log_wr.size(), n0 + 2); end
        else begin
            n_cmp++; if ({log_wr[n0], log_addr[n0], log_data[n0]} !==
                         {1'b1, 28'h15, 32'h6666_0003, 32'h6666_0002, 32'h1234_5678, 32'h6666_0000}) begin
                n_err++; $display("FAIL wmiss_wb: got wr=%b addr=%h data=%h want write 15 with 12345678 in word 1", log_wr[n0], log_addr[n0], log_data[n0]);
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        int st; logic [31:0] rd; bit to; int n0;
        mem_auto = 1'b0;
        @(posedge clk); #1;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h70;
        @(negedge clk);
        n_cmp++; if (bus.proc_stall !== 1'b1) begin n_err++; $display("FAIL rmid_miss_stall: got %b want 1", bus.proc_stall); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rmid_alloc: got mem_read=%b want 1", bus.mem_read); end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.proc_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.mem_read, bus.mem_write, bus.proc_stall} !== 3'b000) begin n_err++; $display("FAIL rmid_after_rst: got rd/wr/stall=%b%b%b want 000", bus.mem_read, bus.mem_write, bus.proc_stall); end
        @(posedge clk); #1;
        inject = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.mem_read, bus.mem_write, bus.proc_stall} !== 3'b000) begin n_err++; $display("FAIL rmid_late_ready: got rd/wr/stall=%b%b%b want 000", bus.mem_read, bus.mem_write, bus.proc_stall); end
        mem_auto = 1'b1;
        n0 = log_wr.size();
        issue(1'b1, 1'b0, 30'h35, 32'h0, st, rd, to);
        n_cmp++; if ({st, rd} !== {32'd5, 32'h7777_0001}) begin n_err++; $display("FAIL rmid_reread35: got stall=%0d data=%h want 5/77770001", st, rd); end
        n_cmp++; if (log_wr.size() !== n0 + 1) begin n_err++; $display("FAIL rmid_txn_count: got %0d want %0d", log_wr.size(), n0 + 1); end
        issue(1'b1, 1'b0, 30'h11, 32'h0, st, rd, to);
        n_cmp++; if ({st, rd} !== {32'd5, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL rmid_reread11: got stall=%0d data=%h want 5/deadbeef", st, rd); end
    endtask

    task automatic test_idle();
        int st; logic [31:0] rd; bit to; int n0;
        n0 = log_wr.size();
        mem_auto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            inject = ($urandom_range(1, 0) != 0);
            @(negedge clk);
            n_cmp++;
            if ({bus.proc_stall, bus.mem_read, bus.mem_write} !== 3'b000) begin
                n_err++; $display("FAIL idle_cycle%0d: got stall/rd/wr=%b%b%b want 000", i, bus.proc_stall, bus.mem_read, bus.mem_write);
            end
        end
        @(posedge clk); #1;
        inject = 1'b0;
        mem_auto = 1'b1;
        issue(1'b1, 1'b0, 30'h11, 32'h0, st, rd, to);
        n_cmp++; if ({st, rd} !== {32'd0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL idle_keep11: got stall=%0d data=%h want 0/deadbeef", st, rd); end
        issue(1'b1, 1'b0, 30'h35, 32'h0, st, rd, to);
        n_cmp++; if ({st, rd} !== {32'd0, 32'h7777_0001}) begin n_err++; $display("FAIL idle_keep35: got stall=%0d data=%h want 0/77770001", st, rd); end
        n_cmp++; if (log_wr.size() !== n0) begin n_err++; $display("FAIL idle_no_mem: got %0d txns want 0", log_wr.size() - n0); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        mem_auto = 1'b1;
        inject   = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h0;
        bus.proc_wdata = 32'h0;
        mem_model[28'h04] = {WD, WC, WB, WA};
        mem_model[28'h0C] = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        mem_model[28'h15] = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
        mem_model[28'h0D] = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_eviction();
        test_write_miss_allocate();
        test_reset_mid_miss();
        test_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_wb_dm.md
Name: dcache_wb_dm

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline core's D-cache port and a slow block-wide main memory. It serves word loads and stores from the core, and raises a stall while a miss is serviced. Misses are serviced by an optional dirty-block write-back followed by a 4-word block refill. The core freezes on stall and holds its request stable.

Parameters:
NUM_BLOCKS, 8, number of cache lines; power of two; index width = log2(NUM_BLOCKS).
WORDS_PER_BLOCK, 4, words per line; fixed at 4, which gives a 128-bit memory bus.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
proc_read  input  1  core load request.
proc_write  input  1  core store request.
proc_addr  input  30  core word address: offset [1:0], index [1+IW:2], tag [29:2+IW].
proc_wdata  input  32  store data.
proc_stall  output  1  high while the current request cannot complete this cycle.
proc_rdata  output  32  load data; valid in the cycle proc_stall is low with proc_read high.
mem_read  output  1  memory block read request.
mem_write  output  1  memory block write request.
mem_addr  output  28  memory block address (word address >> 2).
mem_wdata  output  128  write-back block; word 0 in [31:0].
mem_ready  input  1  one-cycle pulse: the transaction is complete; for reads, mem_rdata is valid.
mem_rdata  input  128  refill block; word 0 in [31:0].

Behaviour:
- Per line state: valid, dirty, tag (28-IW bits), 4x32 data.
- States: COMPARE, WRITEBACK, ALLOCATE.
- Reset (rst high at a clock edge):
  - state=COMPARE; all valid and dirty bits cleared.
  - mem_read=0, mem_write=0.
  - proc_stall=0 while no request is present.
  - Data and tag contents are don't-care.
  - Reset during WRITEBACK or ALLOCATE abandons the transaction; the cache ignores any later mem_ready until a new request.
  - Dirty data present at reset is lost (accepted).
- hit = valid[index] && tag[index]==addr tag.
- req = proc_read | proc_write.
- proc_stall = req && !(state==COMPARE && hit). It is combinational; in COMPARE it is driven from registered array contents.
- No request: proc_stall=0, no state change.
- Read hit (COMPARE): zero-wait; proc_rdata = data[index][offset] in the same cycle.
- Write hit (COMPARE): zero-wait; the selected word is written at the clock edge and dirty[index] is set. The other three words are unchanged.
- Miss in COMPARE:
  - Line dirty and valid -> WRITEBACK.
  - Otherwise -> ALLOCATE.
  - The transition is taken at the edge that ends the miss cycle.
- WRITEBACK:
  - mem_write=1, mem_addr={stored tag, index}, mem_wdata=stored block, all held constant.
  - On mem_ready -> ALLOCATE; mem_write drops in the next cycle.
- ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[29:2], held constant.
  - On mem_ready: the line is loaded with mem_rdata, tag is written, valid=1, dirty=0, then -> COMPARE.
  - The request then hits in COMPARE one cycle later. A store merges at that point and sets dirty.
- Clean-miss latency: 1 (miss) + memory cycles up to and including the mem_ready pulse + 1 (COMPARE hit).
- mem_read and mem_write are never both high. Both are low in COMPARE.
- proc_read and proc_write both high is illegal. The design treats it as a write; the bench flags it with an assertion.
- The core holds proc_addr, proc_wdata and request lines stable while proc_stall=1. Behaviour is undefined otherwise.
- mem_ready while neither mem_read nor mem_write is high is ignored.
- proc_rdata outside a read-hit cycle: data[index][offset] (don't-care).

Decomposition:
- Shared package: state encoding (COMPARE=0, WRITEBACK=1, ALLOCATE=2, 2 bits), WORD_W=32, BLOCK_W=128, offset width 2, index and tag width functions of NUM_BLOCKS.
- One natural sub-module: dcache_line_array, holding the valid/dirty/tag/data storage. It has a word-write port with dirty set, a block-fill port, and a combinational read of line[index]. The FSM and hit logic stay in dcache_wb_dm.

Test Plan:
- Cold read: after reset, read addr 0x10, memory returns mem_ready 3 cycles after mem_read with words {A,B,C,D}.
  - Expect mem_addr=0x4, stall high for 5 cycles, then proc_rdata=A.
  - Then read 0x13 -> D with zero stall.
- Write hit: after the cold fill, write 0x11 with 0xDEADBEEF.
  - Expect stall=0 and no memory activity.
  - Read 0x11 -> 0xDEADBEEF; 0x12 -> C unchanged.
- Dirty eviction: next read 0x31 (same index 4, different tag).
  - Expect mem_write with mem_addr=0x4 and mem_wdata={D,C,0xDEADBEEF,A}.
  - Then mem_read with mem_addr=0xC, then the hit returns the new word 1.
- Write miss allocate: write 0x55 with 0x12345678 to an invalid line.
  - Expect an ALLOCATE fetch of 0x15 only, no write-back.
  - Then a 1-cycle hit that sets dirty.
  - A later conflicting read triggers a write-back containing 0x12345678.
- Reset mid-miss: assert rst for 1 cycle during ALLOCATE before mem_ready.
  - Expect mem_read=0 next cycle and all lines invalid.
  - The late mem_ready is ignored.
  - A re-issued read misses again.
- Idle/no-req: no request for 10 cycles with random mem_ready pulses -> stall=0, mem_read=mem_write=0, contents unchanged.
